// File: rtl/dma_ahb_pkg.sv
// Shared AHB3-Lite encodings and helpers for the DMA address-phase sequencer.
package dma_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BURST = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  localparam int KB_BOUNDARY = 1024;

  // The reserved size code 3 behaves as a word transfer.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [4:0] burst_beats(input logic [1:0] code);
    case (code)
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  function automatic hburst_t burst_hburst(input logic [1:0] code);
    case (code)
      2'd0:    return HBURST_SINGLE;
      2'd1:    return HBURST_INCR4;
      2'd2:    return HBURST_INCR8;
      default: return HBURST_INCR16;
    endcase
  endfunction

endpackage

// File: rtl/dma_haddr_seq_if.sv
// AHB address-phase signals plus the external grant for one DMA stream port.
interface dma_haddr_seq_if
  import dma_ahb_pkg::*;
#(
  parameter int wbus = 32
) ();

  logic [wbus-1:0] haddr;
  htrans_t         htrans;
  hsize_t          hsize;
  hburst_t         hburst;
  logic            grant;
  logic            hready;

  modport master (output haddr, htrans, hsize, hburst, input grant, hready);
  modport slave  (input haddr, htrans, hsize, hburst, output grant, hready);

endinterface

// File: rtl/dma_haddr_step.sv
// Combinational address step and burst-length selection for the sequencer.
module dma_haddr_step
  import dma_ahb_pkg::*;
#(
  parameter int wbus = 32,
  parameter int wcnt = 16
) (
  input  logic [wbus-1:0] addr,
  input  logic [wcnt-1:0] remain,
  input  logic [1:0]      size,
  input  logic            inc,
  input  logic [1:0]      burst,
  input  logic            advance,
  output logic [wbus-1:0] next_addr,
  output logic [4:0]      len,
  output hburst_t         hburst
);

  logic [1:0]      sz;
  logic [wbus-1:0] beat_bytes;
  logic [9:0]      eval_low;
  logic [wcnt-1:0] eval_remain;
  logic [4:0]      nominal;
  logic [10:0]     span_end;
  logic            crosses;
  logic            too_short;
  logic            single;

  assign sz         = eff_size(size);
  assign beat_bytes = wbus'(1) << sz;
  assign next_addr  = inc ? addr + beat_bytes : addr;

  // With advance set the burst is sized for the position after the beat now
  // being accepted, so a back-to-back burst can start without a gap cycle.
  assign eval_low    = advance ? next_addr[9:0] : addr[9:0];
  assign eval_remain = advance ? remain - wcnt'(1) : remain;

  assign nominal   = burst_beats(burst);
  assign span_end  = 11'(eval_low) + (11'(nominal) << sz);
  assign crosses   = span_end > 11'(KB_BOUNDARY);
  assign too_short = eval_remain < wcnt'(nominal);
  assign single    = !inc || too_short || crosses;

  assign len    = single ? 5'd1 : nominal;
  assign hburst = single ? HBURST_SINGLE : burst_hburst(burst);

endmodule

// File: rtl/dma_haddr_seq.sv
// Address-phase sequencer for one DMA stream port on AHB3-Lite.
//
// state    | meaning
// IDLE     | waiting for start; config latched on start
// REQ      | address bus idle, waiting for grant (or abort)
// BURST    | issuing beats of one fixed-length burst
// DRAIN    | last data phase outstanding, wait for hready
// DONE     | one-cycle completion pulse
module dma_haddr_seq
  import dma_ahb_pkg::*;
#(
  parameter int wbus = 32,
  parameter int wcnt = 16
) (
  input  logic            i_clk,
  input  logic            i_nreset,
  input  logic            i_start,
  input  logic [wbus-1:0] i_base,
  input  logic [wcnt-1:0] i_ndata,
  input  logic [1:0]      i_size,
  input  logic            i_inc,
  input  logic [1:0]      i_burst,
  input  logic            i_abort,
  dma_haddr_seq_if.master bus,
  output logic            o_busy,
  output logic            o_done,
  output logic [wcnt-1:0] o_remain
);

  seq_state_t      state_q, state_d;
  logic [wbus-1:0] addr_q, addr_d;
  logic [wcnt-1:0] remain_q, remain_d;
  logic [1:0]      size_q, size_d;
  logic            inc_q, inc_d;
  logic [1:0]      burst_q, burst_d;
  hburst_t         hburst_q, hburst_d;
  logic [4:0]      beats_q, beats_d;
  logic            seq_q, seq_d;

  logic [wbus-1:0] base_aligned;
  logic [wbus-1:0] step_addr;
  logic [4:0]      step_len;
  hburst_t         step_hburst;

  dma_haddr_step #(
    .wbus(wbus),
    .wcnt(wcnt)
  ) u_step (
    .addr      (addr_q),
    .remain    (remain_q),
    .size      (size_q),
    .inc       (inc_q),
    .burst     (burst_q),
    .advance   (state_q == ST_BURST),
    .next_addr (step_addr),
    .len       (step_len),
    .hburst    (step_hburst)
  );

  assign base_aligned = i_base & ~((wbus'(1) << eff_size(i_size)) - wbus'(1));

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      size_q   <= '0;
      inc_q    <= 1'b0;
      burst_q  <= '0;
      hburst_q <= HBURST_SINGLE;
      beats_q  <= '0;
      seq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      size_q   <= size_d;
      inc_q    <= inc_d;
      burst_q  <= burst_d;
      hburst_q <= hburst_d;
      beats_q  <= beats_d;
      seq_q    <= seq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    size_d   = size_q;
    inc_d    = inc_q;
    burst_d  = burst_q;
    hburst_d = hburst_q;
    beats_d  = beats_q;
    seq_d    = seq_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d   = base_aligned;
          remain_d = i_ndata;
          size_d   = i_size;
          inc_d    = i_inc;
          burst_d  = i_burst;
          state_d  = (i_ndata == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (bus.grant) begin
          state_d  = ST_BURST;
          hburst_d = step_hburst;
          beats_d  = step_len;
          seq_d    = 1'b0;
        end
      end
      ST_BURST: begin
        if (bus.hready) begin
          remain_d = remain_q - wcnt'(1);
          addr_d   = step_addr;
          seq_d    = 1'b1;
          beats_d  = beats_q - 5'd1;
          // Grant and abort only matter once the final beat of a burst goes.
          if (beats_q == 5'd1) begin
            if (remain_q == wcnt'(1) || i_abort) begin
              state_d = ST_DRAIN;
            end else if (bus.grant) begin
              hburst_d = step_hburst;
              beats_d  = step_len;
              seq_d    = 1'b0;
            end else begin
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (bus.hready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.haddr  = addr_q;
  assign bus.htrans = (state_q != ST_BURST) ? HTRANS_IDLE :
                      (seq_q ? HTRANS_SEQ : HTRANS_NONSEQ);
  assign bus.hsize  = hsize_t'({1'b0, eff_size(size_q)});
  assign bus.hburst = hburst_q;

  assign o_busy   = (state_q == ST_REQ) || (state_q == ST_BURST) || (state_q == ST_DRAIN);
  assign o_done   = (state_q == ST_DONE);
  assign o_remain = remain_q;

endmodule

// File: tb/tb_dma_haddr_seq.sv
// Bench for dma_haddr_seq: directed and random transfers against a beat-list model.
module tb_dma_haddr_seq;
  import dma_ahb_pkg::*;

  localparam int WBUS = 32;
  localparam int WCNT = 16;

  logic            clk = 1'b0;
  logic            nreset;
  logic            start;
  logic [WBUS-1:0] base;
  logic [WCNT-1:0] ndata;
  logic [1:0]      size;
  logic            inc;
  logic [1:0]      burst;
  logic            abort;
  logic            busy;
  logic            done;
  logic [WCNT-1:0] remain;

  int vectors = 0;
  int miscompares = 0;

  dma_haddr_seq_if #(.wbus(WBUS)) bus_if ();

  dma_haddr_seq #(
    .wbus(WBUS),
    .wcnt(WCNT)
  ) dut (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_start  (start),
    .i_base   (base),
    .i_ndata  (ndata),
    .i_size   (size),
    .i_inc    (inc),
    .i_burst  (burst),
    .i_abort  (abort),
    .bus      (bus_if),
    .o_busy   (busy),
    .o_done   (done),
    .o_remain (remain)
  );

  always #5 clk = ~clk;

  // Expected accepted beats in order, with the burst each belongs to.
  logic [31:0] exp_addr[$];
  logic [1:0]  exp_trans[$];
  logic [2:0]  exp_hburst[$];
  int          exp_bid[$];

  task automatic build_model(input logic [31:0] b, input int n, input logic [1:0] sz,
                             input logic inc_i, input logic [1:0] bc, input int abort_k);
    longint a;
    int step, nom, r, bid, len, cut;
    bit single;
    logic [2:0] code;
    exp_addr.delete(); exp_trans.delete(); exp_hburst.delete(); exp_bid.delete();
    step = 1 << ((sz == 2'd3) ? 2 : int'(sz));
    a    = longint'(b) - (longint'(b) % step);
    nom  = (bc == 2'd0) ? 1 : (bc == 2'd1) ? 4 : (bc == 2'd2) ? 8 : 16;
    code = (bc == 2'd1) ? 3'd3 : (bc == 2'd2) ? 3'd5 : 3'd7;
    r = n; bid = 0;
    while (r > 0) begin
      single = !inc_i || (r < nom) || ((a % 1024) + nom * step > 1024);
      len = single ? 1 : nom;
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(a[31:0]);
        exp_trans.push_back((i == 0) ? 2'd2 : 2'd3);
        exp_hburst.push_back((single || bc == 2'd0) ? 3'd0 : code);
        exp_bid.push_back(bid);
        if (inc_i) a = (a + step) % 64'h1_0000_0000;
        r--;
      end
      bid++;
    end
    if (abort_k < 0) begin
      exp_addr.delete(); exp_trans.delete(); exp_hburst.delete(); exp_bid.delete();
    end else if (abort_k > 0 && abort_k < exp_addr.size()) begin
      cut = exp_bid[abort_k];
      while (exp_bid.size() > 0 && exp_bid[exp_bid.size()-1] > cut) begin
        void'(exp_addr.pop_back()); void'(exp_trans.pop_back());
        void'(exp_hburst.pop_back()); void'(exp_bid.pop_back());
      end
    end
  endtask

  // abort_k: 0 none, -1 asserted with start, k>0 raised once k beats are accepted.
  task automatic run_xfer(input string name, input logic [31:0] b, input int n,
                          input logic [1:0] sz, input logic inc_i, input logic [1:0] bc,
                          input int abort_k, input int stall_beat, input bit rnd);
    int nacc, cyc, nexp, exp_lat, stall_cnt;
    bit seen_done, prev_stall, active;
    logic [31:0] p_addr;
    logic [1:0]  p_trans;
    logic [2:0]  p_hburst;
    logic [2:0]  exp_hsize;
    logic [WCNT-1:0] exp_rem;
    build_model(b, n, sz, inc_i, bc, abort_k);
    nexp      = exp_addr.size();
    exp_rem   = WCNT'(n - nexp);
    exp_hsize = {1'b0, (sz == 2'd3) ? 2'd2 : sz};
    exp_lat   = (nexp == 0) ? ((n == 0) ? 1 : 2) : nexp + 3;
    if (stall_beat >= 0) exp_lat += 2;
    @(negedge clk);
    base = b; ndata = WCNT'(n); size = sz; inc = inc_i; burst = bc;
    abort = (abort_k < 0); start = 1'b1;
    bus_if.grant = 1'b1; bus_if.hready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nacc = 0; seen_done = 0; prev_stall = 0; stall_cnt = 0;
    p_addr = '0; p_trans = '0; p_hburst = '0;
    for (cyc = 1; cyc <= 600 && !seen_done; cyc++) begin
      if (prev_stall) begin
        vectors++;
        if (bus_if.haddr !== p_addr || bus_if.htrans !== p_trans || bus_if.hburst !== p_hburst) begin
          miscompares++;
          $display("FAIL %s stall_hold: got addr=%0h trans=%0d burst=%0d want addr=%0h trans=%0d burst=%0d",
                   name, bus_if.haddr, bus_if.htrans, bus_if.hburst, p_addr, p_trans, p_hburst);
        end
      end
      if (cyc == 1) begin
        vectors++;
        if (busy !== (n != 0)) begin
          miscompares++;
          $display("FAIL %s busy_after_start: got %0b want %0b", name, busy, (n != 0));
        end
      end
      if (done === 1'b1) begin
        seen_done = 1;
        start = 1'b0;
        vectors++;
        if (nacc != nexp || remain !== exp_rem || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s at_done: got beats=%0d remain=%0d busy=%0b want beats=%0d remain=%0d busy=0",
                   name, nacc, remain, busy, nexp, exp_rem);
        end
        if (!rnd) begin
          vectors++;
          if (cyc != exp_lat) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d want %0d", name, cyc, exp_lat);
          end
        end
      end else begin
        active = (bus_if.htrans == HTRANS_NONSEQ) || (bus_if.htrans == HTRANS_SEQ);
        bus_if.hready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (active && nacc == stall_beat && stall_cnt < 2) begin
          bus_if.hready = 1'b0;
          stall_cnt++;
        end
        bus_if.grant = (rnd && abort_k == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
        abort = (abort_k < 0) || (abort_k > 0 && nacc >= abort_k);
        if (rnd && abort_k == 0 && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          base = $urandom;
          ndata = WCNT'($urandom_range(0, 40));
        end else begin
          start = 1'b0;
        end
        prev_stall = active && !bus_if.hready;
        p_addr = bus_if.haddr; p_trans = bus_if.htrans; p_hburst = bus_if.hburst;
        if (active && bus_if.hready) begin
          vectors++;
          if (nacc >= nexp) begin
            miscompares++;
            $display("FAIL %s extra_beat[%0d]: got addr=%0h, want no further beat", name, nacc, bus_if.haddr);
          end else if (bus_if.haddr !== exp_addr[nacc] || bus_if.htrans !== exp_trans[nacc] ||
                       bus_if.hburst !== exp_hburst[nacc] || bus_if.hsize !== exp_hsize ||
                       busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s beat[%0d]: got addr=%0h trans=%0d burst=%0d size=%0d busy=%0b want addr=%0h trans=%0d burst=%0d size=%0d busy=1",
                     name, nacc, bus_if.haddr, bus_if.htrans, bus_if.hburst, bus_if.hsize, busy,
                     exp_addr[nacc], exp_trans[nacc], exp_hburst[nacc], exp_hsize);
          end
          nacc++;
        end
        @(negedge clk);
      end
    end
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got no done after %0d cycles, want done", name, cyc);
    end
    start = 1'b0; abort = 1'b0; bus_if.hready = 1'b1; bus_if.grant = 1'b1;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || remain !== exp_rem) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%0b remain=%0d want done=0 remain=%0d", name, done, remain, exp_rem);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    #2 nreset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus_if.haddr !== '0 || bus_if.htrans !== HTRANS_IDLE || bus_if.hsize !== HSIZE_BYTE ||
        bus_if.hburst !== HBURST_SINGLE) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%0h trans=%0d size=%0d burst=%0d want all 0",
               bus_if.haddr, bus_if.htrans, bus_if.hsize, bus_if.hburst);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || remain !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy=%0b done=%0b remain=%0d want 0/0/0", busy, done, remain);
    end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    @(negedge clk);
    base = 32'h4000; ndata = 16; size = 2'd2; inc = 1'b1; burst = 2'd1; abort = 1'b0; start = 1'b1;
    bus_if.grant = 1'b1; bus_if.hready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (bus_if.htrans != HTRANS_IDLE) hit = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL reset_mid_enter: got no burst, want burst within 10 cycles");
    end
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    vectors++;
    if (bus_if.haddr !== '0 || bus_if.htrans !== HTRANS_IDLE || bus_if.hburst !== HBURST_SINGLE ||
        bus_if.hsize !== HSIZE_BYTE) begin
      miscompares++;
      $display("FAIL reset_mid_bus: got addr=%0h trans=%0d burst=%0d size=%0d want all 0",
               bus_if.haddr, bus_if.htrans, bus_if.hburst, bus_if.hsize);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || remain !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_ctrl: got busy=%0b done=%0b remain=%0d want 0/0/0", busy, done, remain);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet: got done=%0b busy=%0b want 0/0", done, busy);
      end
    end
  endtask

  task automatic test_two_bursts();
    run_xfer("incr4_x2", 32'h1000, 8, 2'd2, 1'b1, 2'd1, 0, -1, 0);
  endtask

  task automatic test_kb_cross();
    run_xfer("kb_cross", 32'h13F8, 4, 2'd2, 1'b1, 2'd1, 0, -1, 0);
  endtask

  task automatic test_fixed_addr();
    run_xfer("fixed_half", 32'h2000, 3, 2'd1, 1'b0, 2'd2, 0, -1, 0);
  endtask

  task automatic test_stall();
    run_xfer("stall", 32'h3000, 16, 2'd2, 1'b1, 2'd1, 0, 6, 0);
  endtask

  task automatic test_abort();
    run_xfer("abort_burst", 32'h5000, 12, 2'd2, 1'b1, 2'd1, 1, -1, 0);
    run_xfer("abort_in_req", 32'h5100, 5, 2'd2, 1'b1, 2'd1, -1, -1, 0);
  endtask

  task automatic test_zero_and_edges();
    run_xfer("ndata_zero", 32'h6000, 0, 2'd2, 1'b1, 2'd1, 0, -1, 0);
    run_xfer("size3_align", 32'h0000_0103, 5, 2'd3, 1'b1, 2'd2, 0, -1, 0);
    run_xfer("incr16_byte", 32'h0000_03F0, 20, 2'd0, 1'b1, 2'd3, 0, -1, 0);
    run_xfer("addr_wrap", 32'hFFFF_FFF8, 4, 2'd2, 1'b1, 2'd0, 0, -1, 0);
  endtask

  task automatic test_random();
    int n, k;
    logic [1:0] sz, bc;
    logic inc_i;
    logic [31:0] b;
    for (int it = 0; it < 25; it++) begin
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b[9:0] = 10'($urandom_range(960, 1023));
      n = $urandom_range(0, 40);
      sz = 2'($urandom_range(0, 3));
      bc = 2'($urandom_range(0, 3));
      inc_i = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run_xfer("random", b, n, sz, inc_i, bc, k, -1, 1);
    end
  endtask

  initial begin
    nreset = 1'b1; start = 1'b0; base = '0; ndata = '0; size = '0; inc = 1'b0;
    burst = '0; abort = 1'b0; bus_if.grant = 1'b0; bus_if.hready = 1'b1;
    test_reset();
    test_two_bursts();
    test_kb_cross();
    test_fixed_addr();
    test_stall();
    test_abort();
    test_zero_and_edges();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
